kf8255_strobed_port: RTL
========================

// Module: kf8255_strobed_port
// PURPOSE
//  Per-port data/handshake stage for one 8255 group: consumes the group mode and port I/O
//  settings and implements mode-0 simple I/O and mode-1 strobed input (STB#/IBF/INTR) or
//  strobed output (OBF#/ACK#/INTR). Sits between the group control register and the pins.
// PARAMETERS
//  DATA_WIDTH   8  port data width
//  SYNC_STAGES  2  flops in the strobe_n/ack_n synchronisers (>=2)
// PORTS
//  clock          in   1   system clock; all state updates on negedge clock
//  reset_n        in   1   asynchronous active-low reset
//  mode_select    in   2   group mode (01 = mode 1; any other value = mode 0 behaviour)
//  port_io        in   1   1 = input, 0 = output
//  mode_update    in   1   one-cycle pulse: group mode/io rewritten
//  inte_set       in   1   one-cycle pulse: set interrupt enable (port C bit set)
//  inte_clear     in   1   one-cycle pulse: clear interrupt enable (port C bit reset)
//  read_port      in   1   one-cycle pulse: CPU reads port
//  write_port     in   1   one-cycle pulse: CPU writes port
//  write_data     in   DW  CPU write data
//  read_data      out  DW  data presented to the internal bus
//  port_in        in   DW  port pins, input direction
//  port_out       out  DW  port pins, output direction
//  strobe_n       in   1   STB#, asynchronous
//  ack_n          in   1   ACK#, asynchronous
//  ibf            out  1   input buffer full
//  obf_n          out  1   output buffer full, active low
//  intr           out  1   interrupt request
// BEHAVIOUR
//  Reset: ibf=0, obf_n=1, intr=0, inte=0, port_out=0, read_data=0, input/output FSMs empty.
//  strobe_n/ack_n pass through SYNC_STAGES flops; a falling/rising edge is a 1-cycle pulse.
//  Mode 0: read_data=port_in registered each clock; write_port latches port_out next edge;
//   ibf=0, obf_n=1, intr=0; strobe/ack edges ignored.
//  Mode 1 input FSM: IN_EMPTY -(STB fall: latch port_in into read_data, ibf=1)-> IN_STROBE
//   -(STB rise: intr=inte)-> IN_FULL -(read_port: ibf=0, intr=0)-> IN_EMPTY.
//   Pin STB# low to ibf high: SYNC_STAGES+1 clocks. read_port in IN_STROBE ignored.
//   STB fall in IN_FULL: overwrite read_data, intr=0, -> IN_STROBE (overrun case).
//   read_port and STB fall together in IN_FULL: STB wins (ibf stays 1, intr=0).
//  Mode 1 output FSM: OUT_EMPTY -(write_port: latch port_out, obf_n=0, intr=0)-> OUT_FULL
//   -(ACK fall: obf_n=1)-> OUT_ACK -(ACK rise: intr=inte)-> OUT_EMPTY.
//   write_port in any state: latch data, obf_n=0, intr=0, -> OUT_FULL; same-cycle ACK edge dropped.
//  inte: inte_clear wins over inte_set; inte=0 forces intr=0 the next edge.
//  mode_update (priority over all): FSMs to EMPTY, ibf=0, obf_n=1, intr=0, inte=0;
//   port_out=0; read_data unchanged. Inputs sampled that cycle are discarded.
//  reset_n low mid-handshake: immediate return to reset values; no partial transfer kept.
// CONFIGURATION
//  KF8255_OVERRUN_DETECT_EN defined: extra output overrun (1 bit, reset 0), set sticky on
//   STB fall in IN_FULL, cleared by read_port or mode_update. Undefined: port absent,
//   overwrite behaviour identical.
// STRUCTURE
//  Package kf8255_pkg: mode constants (MODE_0=00, MODE_1=01), PORT_INPUT=1/PORT_OUTPUT=0,
//   typedef enums in_state_t {IN_EMPTY,IN_STROBE,IN_FULL}, out_state_t {OUT_EMPTY,OUT_FULL,OUT_ACK}.
//  Sub-module kf8255_strobe_sync: SYNC_STAGES synchroniser + fall/rise pulse detector,
//   instantiated twice (strobe_n, ack_n).
// TESTING
//  Reset: reset_n=0 with strobe_n toggling -> ibf=0, obf_n=1, intr=0, port_out=0.
//  Mode1 input, inte=1: port_in=A5, STB# low 4 clk then high -> ibf=1 after 3 clk, read_data=A5,
//   intr=1 after STB rise; read_port -> ibf=0, intr=0 next edge.
//  Mode1 output, inte=1: write_port 3C -> port_out=3C, obf_n=0; ACK# low -> obf_n=1;
//   ACK# high -> intr=1; write_port 55 -> intr=0, obf_n=0.
//  Overrun: second STB# pulse with port_in=5A before read -> read_data=5A, ibf=1,
//   (EN) overrun=1 until read_port.
//  Priority: inte_set+inte_clear same cycle -> inte=0; mode_update during IN_STROBE -> ibf=0,
//   intr=0, later STB rise produces no intr.
//  Mode 0: port_in=0F -> read_data=0F next edge; STB# pulse -> ibf stays 0.

Source files
------------

// File: rtl/kf8255_pkg.sv
// Shared constants and FSM state types for the 8255 strobed port slice.
package kf8255_pkg;

  // Group mode encodings; any value other than MODE_1 behaves as mode 0
  localparam logic [1:0] MODE_0 = 2'b00;
  localparam logic [1:0] MODE_1 = 2'b01;

  // Port direction encodings
  localparam logic PORT_INPUT  = 1'b1;
  localparam logic PORT_OUTPUT = 1'b0;

  typedef enum logic [1:0] {
    IN_EMPTY  = 2'd0,
    IN_STROBE = 2'd1,
    IN_FULL   = 2'd2
  } in_state_t;

  typedef enum logic [1:0] {
    OUT_EMPTY = 2'd0,
    OUT_FULL  = 2'd1,
    OUT_ACK   = 2'd2
  } out_state_t;

endpackage

// File: rtl/kf8255_strobe_sync.sv
// Synchroniser plus edge detector for an asynchronous active-low handshake pin.
// Ports:
//   clock, reset_n : negedge clock, async active-low reset
//   async_n        : raw pin (STB# or ACK#), idle high
//   fall_c         : 1-cycle pulse on a synchronised high->low transition
//   rise_c         : 1-cycle pulse on a synchronised low->high transition
// SYNC_STAGES must be at least 2.
module kf8255_strobe_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic async_n,
  output logic fall_c,
  output logic rise_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Flops reset to the idle-high level so reset never fakes an edge
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_n};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign fall_c = prev_q & ~sync_q[SYNC_STAGES-1];
  assign rise_c = ~prev_q & sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/kf8255_strobed_port.sv
// One 8255 port data/handshake stage: mode-0 simple I/O, mode-1 strobed input
// (STB#/IBF/INTR) and mode-1 strobed output (OBF#/ACK#/INTR).
// Ports:
//   clock, reset_n          : all state on negedge clock, async active-low reset
//   mode_select, port_io    : group mode (01 = mode 1) and direction (1 = input)
//   mode_update             : pulse, reconfiguration; clears handshake state
//   inte_set, inte_clear    : pulses, interrupt enable control (clear wins)
//   read_port, write_port   : CPU access pulses; write_data is the CPU data
//   read_data               : data to the internal bus
//   port_in, port_out       : port pins
//   strobe_n, ack_n         : asynchronous STB# / ACK#
//   ibf, obf_n, intr        : handshake status and interrupt request
//   overrun                 : only with KF8255_OVERRUN_DETECT_EN defined; sticky
//                             flag for a strobe arriving while the buffer is full
module kf8255_strobed_port
  import kf8255_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [1:0]            mode_select,
  input  logic                  port_io,
  input  logic                  mode_update,
  input  logic                  inte_set,
  input  logic                  inte_clear,
  input  logic                  read_port,
  input  logic                  write_port,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  input  logic [DATA_WIDTH-1:0] port_in,
  output logic [DATA_WIDTH-1:0] port_out,
  input  logic                  strobe_n,
  input  logic                  ack_n,
  output logic                  ibf,
  output logic                  obf_n,
  output logic                  intr
`ifdef KF8255_OVERRUN_DETECT_EN
  ,
  output logic                  overrun
`endif
);

  logic stb_fall_c, stb_rise_c;
  logic ack_fall_c, ack_rise_c;

  kf8255_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_stb_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .async_n (strobe_n),
    .fall_c  (stb_fall_c),
    .rise_c  (stb_rise_c)
  );

  kf8255_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .async_n (ack_n),
    .fall_c  (ack_fall_c),
    .rise_c  (ack_rise_c)
  );

  in_state_t             in_state_q, in_state_d;
  out_state_t            out_state_q, out_state_d;
  logic                  inte_q, inte_d;
  logic                  ibf_d, obf_n_d, intr_d;
  logic [DATA_WIDTH-1:0] read_data_d, port_out_d;

  logic mode1_c, strobed_in_c;
  assign mode1_c      = (mode_select == MODE_1);
  assign strobed_in_c = mode1_c & (port_io == PORT_INPUT);

  // State and output registers
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_state_q  <= IN_EMPTY;
      out_state_q <= OUT_EMPTY;
      inte_q      <= 1'b0;
      ibf         <= 1'b0;
      obf_n       <= 1'b1;
      intr        <= 1'b0;
      read_data   <= '0;
      port_out    <= '0;
    end else begin
      in_state_q  <= in_state_d;
      out_state_q <= out_state_d;
      inte_q      <= inte_d;
      ibf         <= ibf_d;
      obf_n       <= obf_n_d;
      intr        <= intr_d;
      read_data   <= read_data_d;
      port_out    <= port_out_d;
    end
  end

  // Next-state and output logic for both handshake FSMs
  always_comb begin
    in_state_d  = in_state_q;
    out_state_d = out_state_q;
    inte_d      = inte_q;
    ibf_d       = ibf;
    obf_n_d     = obf_n;
    intr_d      = intr;
    read_data_d = read_data;
    port_out_d  = port_out;

    if (mode_update) begin
      // Reconfiguration drops every in-flight handshake and discards this cycle's inputs
      in_state_d  = IN_EMPTY;
      out_state_d = OUT_EMPTY;
      inte_d      = 1'b0;
      ibf_d       = 1'b0;
      obf_n_d     = 1'b1;
      intr_d      = 1'b0;
      port_out_d  = '0;
    end else begin
      if (inte_clear) begin
        inte_d = 1'b0;
      end else if (inte_set) begin
        inte_d = 1'b1;
      end

      if (!mode1_c) begin
        // Mode 0: transparent registered input, latched output, no handshake
        in_state_d  = IN_EMPTY;
        out_state_d = OUT_EMPTY;
        ibf_d       = 1'b0;
        obf_n_d     = 1'b1;
        intr_d      = 1'b0;
        read_data_d = port_in;
        if (write_port) begin
          port_out_d = write_data;
        end
      end else if (strobed_in_c) begin
        out_state_d = OUT_EMPTY;
        obf_n_d     = 1'b1;
        case (in_state_q)
          IN_EMPTY: begin
            if (stb_fall_c) begin
              read_data_d = port_in;
              ibf_d       = 1'b1;
              in_state_d  = IN_STROBE;
            end
          end
          IN_STROBE: begin
            if (stb_rise_c) begin
              intr_d     = inte_q;
              in_state_d = IN_FULL;
            end
          end
          IN_FULL: begin
            // A new strobe overwrites unread data and beats a same-cycle read
            if (stb_fall_c) begin
              read_data_d = port_in;
              intr_d      = 1'b0;
              in_state_d  = IN_STROBE;
            end else if (read_port) begin
              ibf_d      = 1'b0;
              intr_d     = 1'b0;
              in_state_d = IN_EMPTY;
            end
          end
          default: in_state_d = IN_EMPTY;
        endcase
      end else begin
        in_state_d = IN_EMPTY;
        ibf_d      = 1'b0;
        if (write_port) begin
          // A write restarts the transfer from any state; a same-cycle ACK edge is lost
          port_out_d  = write_data;
          obf_n_d     = 1'b0;
          intr_d      = 1'b0;
          out_state_d = OUT_FULL;
        end else begin
          case (out_state_q)
            OUT_FULL: begin
              if (ack_fall_c) begin
                obf_n_d     = 1'b1;
                out_state_d = OUT_ACK;
              end
            end
            OUT_ACK: begin
              if (ack_rise_c) begin
                intr_d      = inte_q;
                out_state_d = OUT_EMPTY;
              end
            end
            default: out_state_d = OUT_EMPTY;
          endcase
        end
      end

      // Disabled interrupts drop any pending request on the next edge
      if (!inte_q) begin
        intr_d = 1'b0;
      end
    end
  end

`ifdef KF8255_OVERRUN_DETECT_EN
  logic overrun_d;

  // Sticky overrun flag: set on a strobe into a full buffer, cleared by a read
  always_comb begin
    overrun_d = overrun;
    if (mode_update) begin
      overrun_d = 1'b0;
    end else if (strobed_in_c && (in_state_q == IN_FULL) && stb_fall_c) begin
      overrun_d = 1'b1;
    end else if (read_port) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else begin
      overrun <= overrun_d;
    end
  end
`endif

endmodule
